// File: rtl/lu_multi_op_if.sv
// Operand/result bus for lu_multi_op. The optional parity signal exists only
// when LU_PARITY_EN is defined.
interface lu_multi_op_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clear;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             zero;
    logic [CNT_W-1:0] op_count;
`ifdef LU_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, a, b, op, acc_mode, acc_clear,
        input  out_valid, s, zero, op_count, parity
    );
    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clear,
        output out_valid, s, zero, op_count, parity
    );
`else
    modport master (
        output in_valid, a, b, op, acc_mode, acc_clear,
        input  out_valid, s, zero, op_count
    );
    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clear,
        output out_valid, s, zero, op_count
    );
`endif
endinterface

// File: rtl/lu_multi_op.sv
// Registered 8-op bitwise logic unit with accumulate, zero flag and wrapping
// op counter. Define LU_PARITY_EN to add the registered parity output.
module lu_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       f
);
    always_comb begin
        f = 1'b0;
        case (op)
            3'b000: f = a | b;
            3'b001: f = ~(a | b);
            3'b010: f = a & b;
            3'b011: f = ~(a & b);
            3'b100: f = a ^ b;
            3'b101: f = ~(a ^ b);
            3'b110: f = ~a;
            3'b111: f = a;
            default: f = 1'b0;
        endcase
    end
endmodule

module lu_multi_op #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    lu_multi_op_if.slave  bus
);
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] f;
    logic             zero_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;

    // Accumulate feeds back the pre-edge result, so chains apply one op per cycle.
    assign op_a = bus.acc_mode ? s_q : bus.a;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lu_lane u_lane (
            .op (bus.op),
            .a  (op_a[i]),
            .b  (bus.b[i]),
            .f  (f[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= '0;
            zero_q <= 1'b1;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (bus.acc_clear) begin
            s_q    <= '0;
            zero_q <= 1'b1;
            vld_q  <= 1'b0;
        end else if (bus.in_valid) begin
            s_q    <= f;
            zero_q <= (f == '0);
            vld_q  <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
        end else begin
            vld_q  <= 1'b0;
        end
    end

`ifdef LU_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (reset || bus.acc_clear)
            par_q <= 1'b0;
        else if (bus.in_valid)
            par_q <= ^f;
    end

    assign bus.parity = par_q;
`endif

    assign bus.s         = s_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = vld_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_lu_multi_op.sv
// Directed test of lu_multi_op (WIDTH=8, CNT_W=8) with hand-computed expectations.
module tb_lu_multi_op;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    lu_multi_op_if #(.WIDTH(8), .CNT_W(8)) bus ();

    lu_multi_op #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic am, input logic ac);
        bus.in_valid  = v;
        bus.op        = o;
        bus.a         = av;
        bus.b         = bv;
        bus.acc_mode  = am;
        bus.acc_clear = ac;
    endtask

    task automatic check_par(input string tag, input logic exp);
`ifdef LU_PARITY_EN
        check(tag, {31'd0, bus.parity}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    logic [7:0] all_exp [8];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        all_exp  = '{8'hFC, 8'h03, 8'hC0, 8'h3F, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

        // Reset held 2 cycles with a valid op presented
        reset = 1'b1;
        drive(1'b1, 3'd0, 8'hF0, 8'hCC, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_s",     {24'd0, bus.s}, 32'h00);
        check("rst_zero",  {31'd0, bus.zero}, 32'd1);
        check("rst_vld",   {31'd0, bus.out_valid}, 32'd0);
        check("rst_cnt",   {24'd0, bus.op_count}, 32'd0);
        check_par("rst_par", 1'b0);
        reset = 1'b0;

        // All eight ops back to back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
            tick();
            check($sformatf("op%0d_s", i), {24'd0, bus.s}, {24'd0, all_exp[i]});
            check($sformatf("op%0d_vld", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("op%0d_zero", i), {31'd0, bus.zero}, 32'd0);
            check_par("op_par", 1'b0);
        end
        check("ops_cnt", {24'd0, bus.op_count}, 32'd8);

        // Accumulate chain
        drive(1'b1, 3'd7, 8'h55, 8'h00, 1'b0, 1'b0);
        tick();
        check("acc_pass", {24'd0, bus.s}, 32'h55);
        drive(1'b1, 3'd4, 8'h00, 8'hFF, 1'b1, 1'b0);
        tick();
        check("acc_x1", {24'd0, bus.s}, 32'hAA);
        tick();
        check("acc_x2", {24'd0, bus.s}, 32'h55);
        drive(1'b1, 3'd4, 8'hFF, 8'h55, 1'b1, 1'b0);
        tick();
        check("acc_zs",   {24'd0, bus.s}, 32'h00);
        check("acc_zero", {31'd0, bus.zero}, 32'd1);
        check_par("acc_par", 1'b0);
        check("acc_cnt",  {24'd0, bus.op_count}, 32'd12);

        // Clear wins over a valid op
        drive(1'b1, 3'd4, 8'h00, 8'h0F, 1'b0, 1'b0);
        tick();
        check("pre_clr_s", {24'd0, bus.s}, 32'h0F);
        drive(1'b1, 3'd0, 8'h01, 8'h00, 1'b0, 1'b1);
        tick();
        check("clr_s",    {24'd0, bus.s}, 32'h00);
        check("clr_vld",  {31'd0, bus.out_valid}, 32'd0);
        check("clr_zero", {31'd0, bus.zero}, 32'd1);
        check("clr_cnt",  {24'd0, bus.op_count}, 32'd13);

        // Idle hold after s=3C
        drive(1'b1, 3'd4, 8'hF0, 8'hCC, 1'b0, 1'b0);
        tick();
        check("idle_pre", {24'd0, bus.s}, 32'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'(i), 8'(8'h11 * (i + 1)), 8'(8'h21 * (i + 2)), 1'b0, 1'b0);
            tick();
            check($sformatf("idle%0d_s", i), {24'd0, bus.s}, 32'h3C);
            check($sformatf("idle%0d_vld", i), {31'd0, bus.out_valid}, 32'd0);
            check($sformatf("idle%0d_zero", i), {31'd0, bus.zero}, 32'd0);
        end
        check("idle_cnt", {24'd0, bus.op_count}, 32'd14);

        // Odd-weight result sets parity; then walk the counter to its wrap
        drive(1'b1, 3'd7, 8'h01, 8'h00, 1'b0, 1'b0);
        tick();
        check("par1_s", {24'd0, bus.s}, 32'h01);
        check_par("par1_par", 1'b1);
        for (int i = 0; i < 240; i++) begin
            drive(1'b1, 3'd4, 8'(i), 8'h00, 1'b0, 1'b0);
            tick();
        end
        check("cnt_max", {24'd0, bus.op_count}, 32'd255);
        drive(1'b1, 3'd4, 8'h80, 8'h00, 1'b0, 1'b0);
        tick();
        check("cnt_wrap", {24'd0, bus.op_count}, 32'd0);
        check("wrap_vld", {31'd0, bus.out_valid}, 32'd1);

        // 256 more accepted ops bring the counter back to 0
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 3'd4, 8'(i), 8'h00, 1'b0, 1'b0);
            tick();
        end
        check("cnt256", {24'd0, bus.op_count}, 32'd0);
        check("cnt256_s", {24'd0, bus.s}, 32'hFF);
        check_par("cnt256_par", 1'b0);

        // Reset during a valid op discards it
        drive(1'b1, 3'd7, 8'hAB, 8'h00, 1'b0, 1'b0);
        tick();
        check("pre_rst_cnt", {24'd0, bus.op_count}, 32'd1);
        reset = 1'b1;
        drive(1'b1, 3'd7, 8'hAA, 8'h00, 1'b0, 1'b0);
        tick();
        check("mrst_s",    {24'd0, bus.s}, 32'h00);
        check("mrst_zero", {31'd0, bus.zero}, 32'd1);
        check("mrst_vld",  {31'd0, bus.out_valid}, 32'd0);
        check("mrst_cnt",  {24'd0, bus.op_count}, 32'd0);
        check_par("mrst_par", 1'b0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
